// File: rtl/sw_input_port_pkg.sv
// Shared types and widths for the picoMIPS board I/O blocks (switch input and LED output ports).
package picomips_io_pkg;

   localparam int N_DATA_DEF = 8;
   localparam int SW_W       = N_DATA_DEF + 1;

   typedef enum logic [1:0] {
      LOCKOUT,
      IDLE,
      PRESSED
   } enter_state_t;

endpackage

// File: rtl/sw_input_port_if.sv
// Switch-port bus: raw switch pins in, latched data with valid/ack handshake and overrun flag out.
interface sw_input_port_if #(
   parameter int N_DATA = 8
) ();

   logic [N_DATA:0]   sw;
   logic              rd_ack;
   logic              clr_ovr;
   logic [N_DATA-1:0] data;
   logic              valid;
   logic              overrun;
   logic [N_DATA-1:0] sw_live;

   modport master (
      output sw,
      output rd_ack,
      output clr_ovr,
      input  data,
      input  valid,
      input  overrun,
      input  sw_live
   );

   modport slave (
      input  sw,
      input  rd_ack,
      input  clr_ovr,
      output data,
      output valid,
      output overrun,
      output sw_live
   );

endinterface

// File: rtl/sw_input_port_debounce.sv
// Two-flop synchroniser plus whole-vector debouncer: a new switch value is accepted only
// after it has been seen unchanged for DB_CYCLES further clocks.
module sw_debounce
   import picomips_io_pkg::*;
#(
   parameter int W         = SW_W,
   parameter int DB_CYCLES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] sw,
   output logic [W-1:0] stable,
   output logic [W-1:0] cand,
   output logic         load
);

   localparam int CW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_MAX  = CW'(DB_CYCLES);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   logic [W-1:0]  sync1;
   logic [W-1:0]  sync2;
   logic [CW-1:0] cnt;

   // load marks the edge on which cand is about to be copied into stable
   assign load = (sync2 == cand) && (cnt == DB_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= '0;
         sync2  <= '0;
         cand   <= '0;
         cnt    <= '0;
         stable <= '0;
      end else begin
         sync1 <= sw;
         sync2 <= sync1;
         if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
         end else if (cnt < DB_MAX) begin
            cnt <= cnt + CW'(1);
            if (cnt == DB_LAST) begin
               stable <= cand;
            end
         end
      end
   end

endmodule

// File: rtl/sw_input_port.sv
// Switch input port: debounced switches, one press per ENTER key-down latches the data
// field for the CPU, with valid/ack handshake and a sticky overrun flag.
module sw_input_port
   import picomips_io_pkg::*;
#(
   parameter int N_DATA    = 8,
   parameter int DB_CYCLES = 4
) (
   input  logic            clk,
   input  logic            reset,
   sw_input_port_if.slave  bus
);

   localparam int W = N_DATA + 1;

   logic [W-1:0]      stable;
   logic [W-1:0]      cand;
   logic [W-1:0]      stable_nxt;
   logic              load;
   enter_state_t      state;
   enter_state_t      state_nxt;
   logic              press;
   logic [N_DATA-1:0] data_q;
   logic              valid_q;
   logic              overrun_q;

   sw_debounce #(
      .W         (W),
      .DB_CYCLES (DB_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .sw     (bus.sw),
      .stable (stable),
      .cand   (cand),
      .load   (load)
   );

   // The FSM looks at the value stable takes on this edge, so a press lands in
   // data/valid on the same edge the new switch value appears on sw_live.
   assign stable_nxt = load ? cand : stable;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= LOCKOUT;
      end else begin
         state <= state_nxt;
      end
   end

   // LOCKOUT only leaves once a debounced ENTER=0 has actually been accepted,
   // so a key held through reset never counts as a press.
   always_comb begin
      state_nxt = state;
      press     = 1'b0;
      case (state)
         LOCKOUT: begin
            if (load && !cand[N_DATA]) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            if (stable_nxt[N_DATA]) begin
               state_nxt = PRESSED;
               press     = 1'b1;
            end
         end
         PRESSED: begin
            if (!stable_nxt[N_DATA]) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = LOCKOUT;
         end
      endcase
   end

   // A press beats a same-cycle ack for valid, and an overrun set beats a same-cycle clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (press) begin
            data_q  <= stable_nxt[N_DATA-1:0];
            valid_q <= 1'b1;
         end else if (bus.rd_ack) begin
            valid_q <= 1'b0;
         end
         if (press && valid_q && !bus.rd_ack) begin
            overrun_q <= 1'b1;
         end else if (bus.clr_ovr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign bus.data    = data_q;
   assign bus.valid   = valid_q;
   assign bus.overrun = overrun_q;
   assign bus.sw_live = stable[N_DATA-1:0];

endmodule

// File: tb/tb_sw_input_port.sv
// Bench for sw_input_port: directed switch sequences checked every cycle against a
// history-based model of the debounce/press/handshake rules, plus literal expectations.
module tb_sw_input_port;

   localparam int N  = 8;
   localparam int DB = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic cmp_en = 1'b0;

   int checks = 0;
   int passes = 0;

   sw_input_port_if #(.N_DATA(N)) bus ();

   sw_input_port #(
      .N_DATA    (N),
      .DB_CYCLES (DB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Model state: pin history and window of synchronised samples.
   logic [N:0]   pin_q[$];
   logic [N:0]   win_q[$];
   logic [N:0]   m_stable = '0;
   logic         m_locked = 1'b1;
   logic [N-1:0] m_data   = '0;
   logic         m_valid  = 1'b0;
   logic         m_ovr    = 1'b0;
   logic [N:0]   m_vis;
   logic [N:0]   m_ns;
   logic         m_settled;
   logic         m_press;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [N:0] v, input int cycles);
      @(negedge clk);
      bus.sw = v;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic pulseAck();
      @(negedge clk);
      bus.rd_ack = 1'b1;
      @(negedge clk);
      bus.rd_ack = 1'b0;
   endtask

   task automatic pulseClr();
      @(negedge clk);
      bus.clr_ovr = 1'b1;
      @(negedge clk);
      bus.clr_ovr = 1'b0;
   endtask

   // A value is accepted once DB+1 consecutive synchronised samples agree; the pins reach
   // the debouncer two clocks late. Presses are rising edges of accepted ENTER after lockout.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         pin_q.delete();
         win_q.delete();
         win_q.push_back('0);
         m_stable = '0;
         m_locked = 1'b1;
         m_data   = '0;
         m_valid  = 1'b0;
         m_ovr    = 1'b0;
      end else begin
         pin_q.push_back(bus.sw);
         if (pin_q.size() > 3) void'(pin_q.pop_front());
         m_vis = (pin_q.size() == 3) ? pin_q[0] : '0;
         win_q.push_back(m_vis);
         if (win_q.size() > DB + 1) void'(win_q.pop_front());
         m_settled = (win_q.size() == DB + 1);
         for (int i = 1; i < win_q.size(); i++) begin
            if (win_q[i] != win_q[0]) m_settled = 1'b0;
         end
         m_ns    = m_settled ? win_q[0] : m_stable;
         m_press = !m_locked && m_ns[N] && !m_stable[N];
         if (m_locked && m_settled && !m_ns[N]) m_locked = 1'b0;
         if (bus.clr_ovr) m_ovr = 1'b0;
         if (m_press) begin
            if (m_valid && !bus.rd_ack) m_ovr = 1'b1;
            m_data  = m_ns[N-1:0];
            m_valid = 1'b1;
         end else if (bus.rd_ack) begin
            m_valid = 1'b0;
         end
         m_stable = m_ns;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         checkOutput("cyc_data",    {24'd0, bus.data},    {24'd0, m_data});
         checkOutput("cyc_valid",   {31'd0, bus.valid},   {31'd0, m_valid});
         checkOutput("cyc_overrun", {31'd0, bus.overrun}, {31'd0, m_ovr});
         checkOutput("cyc_sw_live", {24'd0, bus.sw_live}, {24'd0, m_stable[N-1:0]});
      end
   end

   initial begin
      bus.sw      = 9'h1A5;
      bus.rd_ack  = 1'b0;
      bus.clr_ovr = 1'b0;
      #1 reset = 1'b0;
      cmp_en = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_data",    {24'd0, bus.data},    32'h0);
      checkOutput("rst_valid",   {31'd0, bus.valid},   32'h0);
      checkOutput("rst_sw_live", {24'd0, bus.sw_live}, 32'h0);
      reset = 1'b1;

      // ENTER held through reset must not produce a press
      repeat (20) @(negedge clk);
      checkOutput("t1_lockout_valid", {31'd0, bus.valid},   32'h0);
      checkOutput("t1_lockout_live",  {24'd0, bus.sw_live}, 32'hA5);
      applyStimulus(9'h0A5, 10);
      applyStimulus(9'h1A5, 6);
      checkOutput("t1_valid_clk6", {31'd0, bus.valid}, 32'h0);
      @(negedge clk);
      checkOutput("t1_valid_clk7", {31'd0, bus.valid}, 32'h1);
      checkOutput("t1_data",       {24'd0, bus.data},  32'hA5);

      // Bouncing ENTER yields exactly one press
      pulseAck();
      applyStimulus(9'h03C, 10);
      applyStimulus(9'h13C, 2);
      applyStimulus(9'h03C, 2);
      applyStimulus(9'h13C, 2);
      applyStimulus(9'h03C, 2);
      applyStimulus(9'h13C, 10);
      checkOutput("t2_valid", {31'd0, bus.valid}, 32'h1);
      checkOutput("t2_data",  {24'd0, bus.data},  32'h3C);
      repeat (50) @(negedge clk);
      checkOutput("t2_hold_overrun", {31'd0, bus.overrun}, 32'h0);
      checkOutput("t2_hold_valid",   {31'd0, bus.valid},   32'h1);

      // Ack clears valid, data is kept; ack with nothing pending is ignored
      pulseAck();
      checkOutput("t3_ack_valid", {31'd0, bus.valid}, 32'h0);
      checkOutput("t3_ack_data",  {24'd0, bus.data},  32'h3C);
      pulseAck();
      checkOutput("t3_idle_ack_valid", {31'd0, bus.valid}, 32'h0);
      checkOutput("t3_idle_ack_data",  {24'd0, bus.data},  32'h3C);

      // Two presses without ack -> overrun; clr_ovr clears only overrun
      applyStimulus(9'h011, 10);
      applyStimulus(9'h111, 10);
      applyStimulus(9'h022, 10);
      applyStimulus(9'h122, 10);
      checkOutput("t4_data",    {24'd0, bus.data},    32'h22);
      checkOutput("t4_valid",   {31'd0, bus.valid},   32'h1);
      checkOutput("t4_overrun", {31'd0, bus.overrun}, 32'h1);
      pulseClr();
      checkOutput("t4_clr_overrun", {31'd0, bus.overrun}, 32'h0);
      checkOutput("t4_clr_valid",   {31'd0, bus.valid},   32'h1);

      // Ack on the press edge: new data, valid stays, no overrun
      applyStimulus(9'h055, 10);
      applyStimulus(9'h155, 6);
      bus.rd_ack = 1'b1;
      @(negedge clk);
      bus.rd_ack = 1'b0;
      checkOutput("t5_data",    {24'd0, bus.data},    32'h55);
      checkOutput("t5_valid",   {31'd0, bus.valid},   32'h1);
      checkOutput("t5_overrun", {31'd0, bus.overrun}, 32'h0);

      // Asynchronous reset mid-debounce with valid data pending
      applyStimulus(9'h0F0, 3);
      #2 reset = 1'b0;
      #1;
      checkOutput("t6_data",    {24'd0, bus.data},    32'h0);
      checkOutput("t6_valid",   {31'd0, bus.valid},   32'h0);
      checkOutput("t6_overrun", {31'd0, bus.overrun}, 32'h0);
      checkOutput("t6_sw_live", {24'd0, bus.sw_live}, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      applyStimulus(9'h0F0, 10);
      checkOutput("t6_live_after", {24'd0, bus.sw_live}, 32'hF0);
      applyStimulus(9'h1F0, 10);
      checkOutput("t6_press_valid", {31'd0, bus.valid}, 32'h1);
      checkOutput("t6_press_data",  {24'd0, bus.data},  32'hF0);

      @(negedge clk);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
